// File: rtl/gm_rv_ifu_pkg.sv
// gm_rv_ifu shared definitions: FSM encodings, PC step and the
// flag layout of a fetch-queue entry {inst, pc, misalign, fault}.
package gm_rv_ifu_pkg;

    localparam logic [0:0] IFU_ST_RUN  = 1'b0;
    localparam logic [0:0] IFU_ST_HALT = 1'b1;

    localparam int IFU_INST_STEP = 4;

    localparam int FQ_FAULT_BIT    = 0;
    localparam int FQ_MISALIGN_BIT = 1;
    localparam int FQ_FLAG_W       = 2;

endpackage

// File: rtl/gm_rv_ifu_if.sv
// Instruction-memory port of the fetch unit: request handshake plus
// in-order, always-accepted response channel.
interface gm_rv_ifu_if #(
    parameter int ADDR_LEN = 64,
    parameter int INST_LEN = 32
);
    logic                req_valid;
    logic                req_ready;
    logic [ADDR_LEN-1:0] req_addr;
    logic                resp_valid;
    logic [INST_LEN-1:0] resp_data;
    logic                resp_err;

    modport master (
        output req_valid, req_addr,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_addr,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/gm_sync_fifo.sv
// Synchronous FIFO with flush, count, full and empty; a flush may be
// combined with a push, which then becomes the only entry.
module gm_sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rptr_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // storage, pointers and occupancy; flush wins over normal traffic
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (flush_i) begin
            rptr_q <= '0;
            wptr_q <= push_i ? AW'(1) : '0;
            cnt_q  <= push_i ? CW'(1) : '0;
            if (push_i) mem_q[0] <= wdata_i;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= wptr_q + AW'(1);
            end
            if (do_pop) rptr_q <= rptr_q + AW'(1);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/gm_rv_ifu.sv
// In-order fetch unit: sequential imem fetches into a fetch queue,
// redirect flush with stale-response drop. Option: GM_IFU_MISALIGN_EN.
module gm_rv_ifu
    import gm_rv_ifu_pkg::*;
#(
    parameter int                  ADDR_LEN        = 64,
    parameter int                  INST_LEN        = 32,
    parameter logic [ADDR_LEN-1:0] RESET_PC        = ADDR_LEN'(64'h8000_0000),
    parameter int                  FQ_DEPTH        = 4,
    parameter int                  MAX_OUTSTANDING = 2
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    gm_rv_ifu_if.master         imem,
    input  logic                i_redirect_valid,
    input  logic [ADDR_LEN-1:0] i_redirect_pc,
    output logic                o_inst_valid,
    input  logic                i_inst_ready,
    output logic [INST_LEN-1:0] o_cur_inst,
    output logic [ADDR_LEN-1:0] o_cur_pc,
`ifdef GM_IFU_MISALIGN_EN
    output logic                o_inst_misalign,
`endif
    output logic                o_inst_fault
);
    localparam int CW = $clog2(FQ_DEPTH) + 1;
    localparam int EW = INST_LEN + ADDR_LEN + FQ_FLAG_W;
    localparam logic [CW-1:0] MAX_OUT = CW'(MAX_OUTSTANDING);
    localparam logic [CW:0]   FQ_CAP  = (CW + 1)'(FQ_DEPTH);
    localparam logic [ADDR_LEN-1:0] STEP = ADDR_LEN'(IFU_INST_STEP);

    logic [0:0]          state_q, state_d;
    logic [ADDR_LEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_LEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]       out_q, out_d;
    logic [CW-1:0]       drop_q, drop_d;

    logic [CW-1:0]       fq_count;
    logic                fq_full;
    logic                fq_empty;
    logic                fq_push;
    logic                fq_pop;
    logic [EW-1:0]       fq_wdata;
    logic [EW-1:0]       fq_rdata;

    logic [ADDR_LEN-1:0] rd_pc;
    logic                rd_mis;
    logic                fire;
    logic [CW:0]         in_use;

    assign rd_pc  = {i_redirect_pc[ADDR_LEN-1:2], 2'b00};
`ifdef GM_IFU_MISALIGN_EN
    assign rd_mis = |i_redirect_pc[1:0];
`else
    assign rd_mis = 1'b0;
`endif

    // a request needs both an imem slot and a reserved queue slot
    assign in_use = {1'b0, out_q} + {1'b0, fq_count};
    assign imem.req_valid = i_rst_n
                          & (state_q == IFU_ST_RUN)
                          & (out_q < MAX_OUT)
                          & (in_use < FQ_CAP)
                          & ~i_redirect_valid;
    assign imem.req_addr  = fetch_pc_q;
    assign fire           = imem.req_valid & imem.req_ready;

    assign o_inst_valid = ~fq_empty;
    assign o_cur_inst   = fq_rdata[EW-1 -: INST_LEN];
    assign o_cur_pc     = fq_rdata[FQ_FLAG_W +: ADDR_LEN];
    assign o_inst_fault = fq_rdata[FQ_FAULT_BIT];
`ifdef GM_IFU_MISALIGN_EN
    assign o_inst_misalign = fq_rdata[FQ_MISALIGN_BIT];
    logic unused_fq;
    assign unused_fq = fq_full;
`else
    logic unused_fq;
    assign unused_fq = fq_full ^ fq_rdata[FQ_MISALIGN_BIT];
`endif

    // next-state: redirect overrides fetch advance and response handling
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        out_d      = out_q + CW'(fire) - CW'(imem.resp_valid);
        drop_d     = drop_q;
        fq_push    = 1'b0;
        fq_wdata   = '0;
        fq_pop     = o_inst_valid & i_inst_ready & ~i_redirect_valid;
        if (i_redirect_valid) begin
            fetch_pc_d = rd_pc;
            resp_pc_d  = rd_pc;
            drop_d     = out_d;
            state_d    = IFU_ST_RUN;
            if (rd_mis) begin
                fq_push  = 1'b1;
                fq_wdata = {{INST_LEN{1'b0}}, i_redirect_pc, 1'b1, 1'b0};
                state_d  = IFU_ST_HALT;
            end
        end else begin
            if (fire) fetch_pc_d = fetch_pc_q + STEP;
            if (imem.resp_valid) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CW'(1);
                end else begin
                    fq_push   = 1'b1;
                    fq_wdata  = {imem.resp_err ? '0 : imem.resp_data,
                                 resp_pc_q, 1'b0, imem.resp_err};
                    resp_pc_d = resp_pc_q + STEP;
                    if (imem.resp_err) state_d = IFU_ST_HALT;
                end
            end
        end
    end

    // architectural state of the fetch engine
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IFU_ST_RUN;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
        end
    end

    gm_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FQ_DEPTH)
    ) u_fq (
        .clk_i   (i_clk),
        .rst_ni  (i_rst_n),
        .flush_i (i_redirect_valid),
        .push_i  (fq_push),
        .wdata_i (fq_wdata),
        .pop_i   (fq_pop),
        .rdata_o (fq_rdata),
        .count_o (fq_count),
        .full_o  (fq_full),
        .empty_o (fq_empty)
    );
endmodule
